// File: rtl/hartslag_meter.sv
// Heartbeat front end: synchronises and debounces the raw sensor pulse, measures
// beat-to-beat intervals in ms, averages the last four and reports a rate class.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// ST_LOST   | no reference beat; next beat event only arms the interval timer
// ST_ARMED  | reference beat seen, waiting for first interval >= refractory
// ST_TRACK  | at least one accepted interval since last signal loss
module hartslag_meter #(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned DEB_LEN    = 8,
  parameter int unsigned REFRACT_MS = 250,
  parameter int unsigned TIMEOUT_MS = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hartslagIngang,
  output logic [2:0]  hartslag,
  output logic [11:0] periode,
  output logic        geldig,
  output logic        beat
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = $clog2(DEB_LEN + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_LEN - 1);
  localparam logic [11:0]   REFRACT   = 12'(REFRACT_MS);
  localparam logic [11:0]   TIMEOUT   = 12'(TIMEOUT_MS);
  localparam logic [11:0]   INT_MAX   = 12'hFFF;

  localparam logic [1:0] ST_LOST  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;

  logic rst_meta_q, rst_sync_q;
  logic rst_int_n;

  logic sync_meta_q, sync_q;

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick_w;

  logic          deb_level_q, deb_level_d;
  logic [DW-1:0] deb_run_q, deb_run_d;
  logic          deb_prev_q;
  logic          beat_evt_w;

  logic [1:0]  state_q, state_d;
  logic [11:0] interval_q, interval_d;
  logic [2:0]  fill_q, fill_d;
  logic [11:0] hist_q [4];
  logic        beat_q, beat_d;

  logic        timeout_w, accept_w, arm_w;
  logic [13:0] sum_w;
  logic [11:0] avg_w;
  logic        out_valid_w;

  logic [2:0]  hartslag_q, hartslag_d;
  logic [11:0] periode_q, periode_d;
  logic        geldig_q, geldig_d;

  // Asserts immediately, releases two clocks after reset goes high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign rst_int_n = rst_sync_q;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      sync_meta_q <= hartslagIngang;
      sync_q      <= sync_meta_q;
    end
  end

  assign tick_w     = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick_w ? '0 : tick_cnt_q + 1'b1;

  always_comb begin
    deb_level_d = deb_level_q;
    deb_run_d   = deb_run_q;
    if (tick_w) begin
      if (sync_q != deb_level_q) begin
        if (deb_run_q == DEB_LAST) begin
          deb_level_d = sync_q;
          deb_run_d   = '0;
        end else begin
          deb_run_d = deb_run_q + 1'b1;
        end
      end else begin
        deb_run_d = '0;
      end
    end
  end

  assign beat_evt_w = deb_level_q & ~deb_prev_q;

  // Timeout has priority; a coincident beat re-arms as if seen from ST_LOST.
  assign timeout_w = (state_q != ST_LOST) && (interval_q >= TIMEOUT);
  assign arm_w     = beat_evt_w && ((state_q == ST_LOST) || timeout_w);
  assign accept_w  = beat_evt_w && !timeout_w && (state_q != ST_LOST) &&
                     (interval_q >= REFRACT);

  always_comb begin
    state_d    = state_q;
    interval_d = interval_q;
    fill_d     = fill_q;
    beat_d     = accept_w;

    if (arm_w || accept_w) begin
      interval_d = '0;
    end else if (tick_w && (interval_q != INT_MAX)) begin
      interval_d = interval_q + 12'd1;
    end

    if (arm_w) begin
      state_d = ST_ARMED;
    end else if (timeout_w) begin
      state_d = ST_LOST;
    end else if (accept_w) begin
      state_d = ST_TRACK;
    end

    if (timeout_w) begin
      fill_d = '0;
    end else if (accept_w && (fill_q != 3'd4)) begin
      fill_d = fill_q + 3'd1;
    end
  end

  assign sum_w = {2'b00, hist_q[0]} + {2'b00, hist_q[1]} +
                 {2'b00, hist_q[2]} + {2'b00, hist_q[3]};
  assign avg_w = 12'(sum_w >> 2);

  function automatic logic [2:0] rate_class(input logic [11:0] p);
    if (p >= 12'd1000)     return 3'd1;
    else if (p >= 12'd857) return 3'd2;
    else if (p >= 12'd750) return 3'd3;
    else if (p >= 12'd667) return 3'd4;
    else if (p >= 12'd600) return 3'd5;
    else if (p >= 12'd500) return 3'd6;
    else                   return 3'd7;
  endfunction

  assign out_valid_w = (fill_q == 3'd4) && !timeout_w;

  always_comb begin
    geldig_d   = out_valid_w;
    periode_d  = '0;
    hartslag_d = '0;
    if (out_valid_w) begin
      periode_d  = avg_w;
      hartslag_d = rate_class(avg_w);
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      tick_cnt_q  <= '0;
      deb_level_q <= 1'b0;
      deb_run_q   <= '0;
      deb_prev_q  <= 1'b0;
      state_q     <= ST_LOST;
      interval_q  <= '0;
      fill_q      <= '0;
      beat_q      <= 1'b0;
      hartslag_q  <= '0;
      periode_q   <= '0;
      geldig_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      deb_level_q <= deb_level_d;
      deb_run_q   <= deb_run_d;
      deb_prev_q  <= deb_level_q;
      state_q     <= state_d;
      interval_q  <= interval_d;
      fill_q      <= fill_d;
      beat_q      <= beat_d;
      hartslag_q  <= hartslag_d;
      periode_q   <= periode_d;
      geldig_q    <= geldig_d;
      if (accept_w) begin
        hist_q[0] <= interval_q;
        for (int i = 1; i < 4; i++) begin
          hist_q[i] <= hist_q[i-1];
        end
      end
    end
  end

  assign hartslag = hartslag_q;
  assign periode  = periode_q;
  assign geldig   = geldig_q;
  assign beat     = beat_q;

endmodule

// File: tb/tb_hartslag_meter.sv
// Bench for hartslag_meter: directed pulse trains; each expected beat response is
// queued at stimulus time and checked by a monitor one cycle after the beat pulse.
module tb_hartslag_meter;

  localparam int TICK_DIV   = 10;
  localparam int DEB_LEN    = 8;
  localparam int REFRACT_MS = 250;
  // Shorter loss timeout keeps the whole run compact.
  localparam int TIMEOUT_MS = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        hin;
  logic [2:0]  hartslag;
  logic [11:0] periode;
  logic        geldig;
  logic        beat;

  hartslag_meter #(
    .TICK_DIV  (TICK_DIV),
    .DEB_LEN   (DEB_LEN),
    .REFRACT_MS(REFRACT_MS),
    .TIMEOUT_MS(TIMEOUT_MS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .hartslagIngang(hin),
    .hartslag      (hartslag),
    .periode       (periode),
    .geldig        (geldig),
    .beat          (beat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [11:0] per;
    logic [2:0]  cls;
    logic        vld;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   beats_seen = 0;
  int   beats_pushed = 0;
  int   last_beat_cyc = -1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int id, input int per, input int cls, input int vld);
    exp_t e;
    e.id  = id;
    e.per = 12'(per);
    e.cls = 3'(cls);
    e.vld = 1'(vld);
    exp_q.push_back(e);
    beats_pushed++;
  endtask

  // One 50 ms pulse per period; optional 5-tick glitches and a refractory extra pulse.
  task automatic pulse(input int period, input bit glitch, input bit extra);
    hin = 1'b1;
    wait_cyc(200);
    if (glitch) begin
      hin = 1'b0;
      wait_cyc(50);
      hin = 1'b1;
    end else begin
      wait_cyc(50);
    end
    wait_cyc(250);
    hin = 1'b0;
    if (extra) begin
      wait_cyc(500);
      hin = 1'b1;
      wait_cyc(300);
      hin = 1'b0;
      wait_cyc(1200);
    end else begin
      wait_cyc(2000);
    end
    if (glitch) begin
      hin = 1'b1;
      wait_cyc(50);
      hin = 1'b0;
      wait_cyc(period - 2550);
    end else begin
      wait_cyc(period - 2500);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_geldig"}, int'(geldig), 0);
    chk({tag, "_periode"}, int'(periode), 0);
    chk({tag, "_hartslag"}, int'(hartslag), 0);
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (beat === 1'b1) begin
        last_beat_cyc = cyc;
        beats_seen++;
        @(negedge clk);
        chk("beat_width", int'(beat), 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: beat at cycle %0d, required no beat", last_beat_cyc);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("periode[%0d]", e.id), int'(periode), int'(e.per));
          chk($sformatf("hartslag[%0d]", e.id), int'(hartslag), int'(e.cls));
          chk($sformatf("geldig[%0d]", e.id), int'(geldig), int'(e.vld));
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int target;
    int guard;
    reset = 1'b1;
    hin   = 1'b0;
    #2 reset = 1'b0;

    // Reset held with a toggling input
    for (int i = 0; i < 12; i++) begin
      wait_cyc(3);
      hin = ~hin;
      if (i % 4 == 3) chk_zero("in_reset");
    end
    hin = 1'b0;
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(1000);
    chk_zero("idle");
    chk("idle_beats", beats_seen, 0);

    // Steady 800 ms with glitches; extra pulse after the locking beat
    pulse(8000, 1'b1, 1'b0);
    for (int k = 2; k <= 6; k++) begin
      if (k < 5) push_exp(k, 0, 0, 0);
      else       push_exp(k, 800, 3, 1);
      pulse((k == 6) ? 3000 : 8000, 1'b1, (k == 5));
    end

    // 7-tick pulse must not be accepted
    hin = 1'b1;
    wait_cyc(70);
    hin = 1'b0;
    wait_cyc(200);
    chk("short_pulse_beats", beats_seen, 5);

    // Loss of signal: geldig drops TIMEOUT_MS ticks after the last beat
    target = last_beat_cyc + TICK_DIV * TIMEOUT_MS;
    guard = 0;
    while (cyc < target - 1 && guard < 20000) begin
      wait_cyc(1);
      guard++;
    end
    chk("timeout_wait_cycle", cyc, target - 1);
    chk("pre_timeout_geldig", int'(geldig), 1);
    chk("pre_timeout_periode", int'(periode), 800);
    wait_cyc(1);
    chk_zero("timeout");

    // Resume at 500 ms
    wait_cyc(100);
    pulse(5000, 1'b0, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      if (k < 5) push_exp(10 + k, 0, 0, 0);
      else       push_exp(10 + k, 500, 6, 1);
      pulse((k == 5) ? 2600 : 5000, 1'b0, 1'b0);
    end
    chk("locked_500_geldig", int'(geldig), 1);

    // Reset mid-lock
    reset = 1'b0;
    #1;
    chk_zero("mid_reset");
    chk("mid_reset_beat", int'(beat), 0);
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(20);
    chk_zero("after_reset");

    // Re-lock at 300 ms
    pulse(3000, 1'b0, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      if (k < 5) push_exp(20 + k, 0, 0, 0);
      else       push_exp(20 + k, 300, 7, 1);
      pulse((k == 5) ? 2600 : 3000, 1'b0, 1'b0);
    end
    wait_cyc(10);
    chk("final_periode", int'(periode), 300);
    chk("final_hartslag", int'(hartslag), 7);
    chk("pending_expected", exp_q.size(), 0);
    chk("beat_total", beats_seen, beats_pushed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
